// File: rtl/parking_gate_controller_pkg.sv
// Shared definitions for the parking gate controller.
// Holds the FSM state encoding and the default configuration constants.
// No ports (package).
package parking_pkg;

    localparam int unsigned DEFAULT_CAPACITY    = 8;
    localparam int unsigned DEFAULT_OPEN_CYCLES = 20;
    localparam int unsigned DEFAULT_CNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OPEN_IN  = 2'd1,
        OPEN_OUT = 2'd2
    } gate_state_e;

endpackage

// File: rtl/parking_gate_controller_if.sv
// Signal bundle between the gate controller and its environment.
// master: drives the buttons and observes the gate/occupancy status.
// slave : the controller; samples the buttons and drives the status.
//   entryButton, exitButton : debounced request levels
//   gateOpen, gateDir       : gate actuator and direction (1 = entry)
//   occupancy, full, empty  : car count and its decodes
//   rejected                : one-cycle pulse per dropped request
interface parking_gate_controller_if #(
    parameter int unsigned CNT_W = parking_pkg::DEFAULT_CNT_W
);

    logic             entryButton;
    logic             exitButton;
    logic             gateOpen;
    logic             gateDir;
    logic [CNT_W-1:0] occupancy;
    logic             full;
    logic             empty;
    logic             rejected;

    modport master (
        output entryButton, exitButton,
        input  gateOpen, gateDir, occupancy, full, empty, rejected
    );

    modport slave (
        input  entryButton, exitButton,
        output gateOpen, gateDir, occupancy, full, empty, rejected
    );

endinterface

// File: rtl/parking_gate_controller_edge_detect.sv
// Rising-edge detector for a synchronous level.
//   clk, rst : clock, asynchronous active-high reset
//   level_i  : input level
//   pulse_c  : combinational one-cycle pulse on a low-to-high transition
// The detector is disarmed by reset and only arms once the level has been
// seen low, so a level already high at reset release produces no pulse.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic pulse_c
);

    logic prev_q;
    logic armed_q;

    // Previous-level register and arming flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q <= level_i;
            if (!level_i) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign pulse_c = level_i & ~prev_q & armed_q;

endmodule

// File: rtl/parking_gate_controller.sv
// Parking gate controller: counts cars, opens the gate for a fixed window
// per granted entry/exit request and rejects requests it cannot serve.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of parking_gate_controller_if
//              (entryButton/exitButton in; gateOpen, gateDir, occupancy,
//               full, empty, rejected out)
// Build option: PARK_EXIT_PRIORITY_EN -- when defined, simultaneous servable
// requests grant exit first; otherwise entry first.
module parking_gate_controller
    import parking_pkg::*;
#(
    parameter int unsigned CAPACITY    = DEFAULT_CAPACITY,
    parameter int unsigned OPEN_CYCLES = DEFAULT_OPEN_CYCLES,
    parameter int unsigned CNT_W       = DEFAULT_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    parking_gate_controller_if.slave  bus
);

    localparam int unsigned TMR_W = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);

`ifdef PARK_EXIT_PRIORITY_EN
    localparam bit EXIT_FIRST = 1'b1;
`else
    localparam bit EXIT_FIRST = 1'b0;
`endif

    gate_state_e      state_q, state_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             pend_in_q, pend_in_d;
    logic             pend_out_q, pend_out_d;
    logic             gate_open_q, gate_open_d;
    logic             gate_dir_q, gate_dir_d;
    logic             rej_q, rej_d;

    logic entry_pulse_c, exit_pulse_c;
    logic full_c, empty_c;
    logic can_in_c, can_out_c;
    logic clr_in_c, clr_out_c;

    edge_detect u_entry_edge (
        .clk     (clk),
        .rst     (rst),
        .level_i (bus.entryButton),
        .pulse_c (entry_pulse_c)
    );

    edge_detect u_exit_edge (
        .clk     (clk),
        .rst     (rst),
        .level_i (bus.exitButton),
        .pulse_c (exit_pulse_c)
    );

    assign full_c    = (occ_q == CAP);
    assign empty_c   = (occ_q == '0);
    assign can_in_c  = pend_in_q  && !full_c;
    assign can_out_c = pend_out_q && !empty_c;

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        occ_d       = occ_q;
        tmr_d       = tmr_q;
        gate_open_d = gate_open_q;
        gate_dir_d  = gate_dir_q;
        rej_d       = 1'b0;
        clr_in_c    = 1'b0;
        clr_out_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (can_out_c && (EXIT_FIRST || !can_in_c)) begin
                    state_d     = OPEN_OUT;
                    occ_d       = occ_q - CNT_W'(1);
                    tmr_d       = TMR_LOAD;
                    gate_open_d = 1'b1;
                    gate_dir_d  = 1'b0;
                    clr_out_c   = 1'b1;
                end else if (can_in_c) begin
                    state_d     = OPEN_IN;
                    occ_d       = occ_q + CNT_W'(1);
                    tmr_d       = TMR_LOAD;
                    gate_open_d = 1'b1;
                    gate_dir_d  = 1'b1;
                    clr_in_c    = 1'b1;
                end
                // Unservable requests are dropped now rather than left to
                // become servable once the other direction changes the count.
                if ((pend_in_q && full_c) || (pend_out_q && empty_c)) begin
                    rej_d = 1'b1;
                    if (pend_in_q && full_c) begin
                        clr_in_c = 1'b1;
                    end
                    if (pend_out_q && empty_c) begin
                        clr_out_c = 1'b1;
                    end
                end
            end
            OPEN_IN, OPEN_OUT: begin
                if (tmr_q == '0) begin
                    state_d     = IDLE;
                    gate_open_d = 1'b0;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                gate_open_d = 1'b0;
            end
        endcase

        // An edge arriving while already pending is absorbed.
        pend_in_d  = clr_in_c  ? 1'b0 : (pend_in_q  | entry_pulse_c);
        pend_out_d = clr_out_c ? 1'b0 : (pend_out_q | exit_pulse_c);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            occ_q       <= '0;
            tmr_q       <= '0;
            pend_in_q   <= 1'b0;
            pend_out_q  <= 1'b0;
            gate_open_q <= 1'b0;
            gate_dir_q  <= 1'b0;
            rej_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            tmr_q       <= tmr_d;
            pend_in_q   <= pend_in_d;
            pend_out_q  <= pend_out_d;
            gate_open_q <= gate_open_d;
            gate_dir_q  <= gate_dir_d;
            rej_q       <= rej_d;
        end
    end

    assign bus.gateOpen  = gate_open_q;
    assign bus.gateDir   = gate_dir_q;
    assign bus.occupancy = occ_q;
    assign bus.full      = full_c;
    assign bus.empty     = empty_c;
    assign bus.rejected  = rej_q;

endmodule
